// File: rtl/rom_block_server.sv
// rom_block_server: cache-refill responder that reads one 64-byte block from a
// 32-bit synchronous ROM as 16 word reads, assembles it and pulses blk_valid.
// Optional build macro: CRITICAL_WORD_FIRST_EN (wrapped issue order starting at
// the requested word, plus crit_valid / crit_word outputs).
module rom_block_server #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          req_valid,
  input  logic [ADDR_W-1:0]             req_addr,
  output logic                          req_ready,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [WORD_W-1:0]             mem_data,
  output logic [BLOCK_WORDS*WORD_W-1:0] blk_data,
  output logic                          blk_valid,
  output logic                          busy
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                          crit_valid,
  output logic [WORD_W-1:0]             crit_word
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nx_s;
  logic                            ready_r;
  logic                            busy_r;
  logic                            blk_valid_r;
  logic                            ready_nx_s;
  logic                            busy_nx_s;
  logic                            blk_valid_nx_s;

  logic                            mem_rd_r;
  logic [ADDR_W-1:0]               mem_addr_r;
  logic [3:0]                      issue_cnt_r;
  logic [3:0]                      cap_cnt_r;
  logic [MEM_LATENCY-1:0]          pipe_v_r;
  logic [3:0]                      pipe_i_r [MEM_LATENCY];
  logic [BLOCK_WORDS*WORD_W-1:0]   blk_data_r;

  logic                            accept_s;
  logic                            cap_valid_s;
  logic [3:0]                      cap_idx_s;
  logic                            last_cap_s;
  logic [3:0]                      start_s;
  logic                            unused_s;

  // The low address bits only select the starting word (or nothing at all).
  assign unused_s    = ^req_addr[5:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_s     = req_addr[5:2];
`else
  assign start_s     = 4'd0;
`endif

  assign req_ready   = ready_r & ~sys_rst;
  assign accept_s    = req_valid & req_ready;
  assign cap_valid_s = pipe_v_r[MEM_LATENCY-1];
  assign cap_idx_s   = pipe_i_r[MEM_LATENCY-1];
  assign last_cap_s  = cap_valid_s && (cap_cnt_r == 4'd15);

  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign blk_data    = blk_data_r;
  assign blk_valid   = blk_valid_r;
  assign busy        = busy_r;

  // State register plus the registered status outputs that follow it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= IDLE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      blk_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ready_r     <= ready_nx_s;
      busy_r      <= busy_nx_s;
      blk_valid_r <= blk_valid_nx_s;
    end
  end

  // Next-state: leave FETCH only once the 16th word has landed in blk_data.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = FETCH;
        else          state_nx_s = IDLE;
      end
      FETCH: begin
        if (last_cap_s) state_nx_s = DONE;
        else            state_nx_s = FETCH;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode on the next state so the registered outputs line up with it.
  always_comb begin
    ready_nx_s     = 1'b0;
    busy_nx_s      = 1'b0;
    blk_valid_nx_s = 1'b0;
    case (state_nx_s)
      IDLE:    ready_nx_s = 1'b1;
      FETCH:   busy_nx_s  = 1'b1;
      DONE: begin
        busy_nx_s      = 1'b1;
        blk_valid_nx_s = 1'b1;
      end
      default: ready_nx_s = 1'b1;
    endcase
  end

  // Issue side: 16 word reads, index wraps inside the block so no carry into bit 6.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      issue_cnt_r <= 4'd0;
    end else if (accept_s) begin
      mem_rd_r    <= 1'b1;
      mem_addr_r  <= {req_addr[ADDR_W-1:6], start_s, 2'b00};
      issue_cnt_r <= 4'd0;
    end else if (mem_rd_r) begin
      if (issue_cnt_r == 4'd15) begin
        mem_rd_r <= 1'b0;
      end else begin
        issue_cnt_r <= issue_cnt_r + 4'd1;
        mem_addr_r  <= {mem_addr_r[ADDR_W-1:6], mem_addr_r[5:2] + 4'd1, 2'b00};
      end
    end
  end

  // Capture side: delay (valid, word index) by the ROM latency, then place the word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pipe_v_r   <= {MEM_LATENCY{1'b0}};
      for (int j = 0; j < MEM_LATENCY; j++) pipe_i_r[j] <= 4'd0;
      cap_cnt_r  <= 4'd0;
      blk_data_r <= {(BLOCK_WORDS*WORD_W){1'b0}};
    end else begin
      pipe_v_r[0] <= mem_rd_r;
      pipe_i_r[0] <= mem_addr_r[5:2];
      for (int j = 1; j < MEM_LATENCY; j++) begin
        pipe_v_r[j] <= pipe_v_r[j-1];
        pipe_i_r[j] <= pipe_i_r[j-1];
      end
      if (accept_s) begin
        cap_cnt_r <= 4'd0;
      end else if (cap_valid_s) begin
        cap_cnt_r <= cap_cnt_r + 4'd1;
      end
      if (cap_valid_s) begin
        blk_data_r[int'(cap_idx_s) * WORD_W +: WORD_W] <= mem_data;
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic              crit_valid_r;
  logic [WORD_W-1:0] crit_word_r;

  assign crit_valid = crit_valid_r;
  assign crit_word  = crit_word_r;

  // The first word captured in a fetch is always the requested (critical) word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      crit_valid_r <= 1'b0;
      crit_word_r  <= {WORD_W{1'b0}};
    end else begin
      crit_valid_r <= cap_valid_s && (cap_cnt_r == 4'd0);
      if (cap_valid_s && (cap_cnt_r == 4'd0)) begin
        crit_word_r <= mem_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_block_server.sv
// Directed bench for rom_block_server: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=4, each fed by a ROM model whose data equals the read address.
module tb_rom_block_server;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         rv1, rr1, rd1, bv1, bs1;
  logic [31:0]  ra1, ma1, md1;
  logic [511:0] bd1;
  logic         rv4, rr4, rd4, bv4, bs4;
  logic [31:0]  ra4, ma4, md4;
  logic [511:0] bd4;
`ifdef CRITICAL_WORD_FIRST_EN
  logic         cv1, cv4;
  logic [31:0]  cw1, cw4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  rom_block_server #(.MEM_LATENCY(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(rv1), .req_addr(ra1),
    .req_ready(rr1), .mem_rd(rd1), .mem_addr(ma1), .mem_data(md1),
    .blk_data(bd1), .blk_valid(bv1), .busy(bs1)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(cv1), .crit_word(cw1)
`endif
  );

  rom_block_server #(.MEM_LATENCY(4)) u_dut4 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(rv4), .req_addr(ra4),
    .req_ready(rr4), .mem_rd(rd4), .mem_addr(ma4), .mem_data(md4),
    .blk_data(bd4), .blk_valid(bv4), .busy(bs4)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(cv4), .crit_word(cw4)
`endif
  );

  // ROM models: data is the address, delayed by the latency of each instance.
  logic [31:0] rom1_q = 32'd0;
  logic [31:0] rom4_q [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  always @(posedge clk) begin
    rom1_q    <= ma1;
    rom4_q[0] <= ma4;
    for (int i = 1; i < 4; i++) rom4_q[i] <= rom4_q[i-1];
  end
  assign md1 = rom1_q;
  assign md4 = rom4_q[3];

  // Address expected at sample m (m = cycles after the accepting edge, from 0).
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int m);
    logic [3:0] s;
    logic [3:0] idx;
`ifdef CRITICAL_WORD_FIRST_EN
    s = a[5:2];
`else
    s = 4'd0;
`endif
    idx = s + m[3:0];
    return {a[31:6], idx, 2'b00};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rv1 = 1'b0; ra1 = 32'd0; rv4 = 1'b0; ra4 = 32'd0;
    repeat (2) @(negedge clk);
    n_chk++; if (rr1 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %0h want 0", rr1); end
    n_chk++; if (rd1 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %0h want 0", rd1); end
    n_chk++; if (ma1 !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0h want 0", ma1); end
    n_chk++; if (bd1 !== 512'd0) begin n_fail++; $display("FAIL reset_blk_data got nonzero want 0"); end
    n_chk++; if (bv1 !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid got %0h want 0", bv1); end
    n_chk++; if (bs1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", bs1); end
    n_chk++; if (rr4 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready4 got %0h want 0", rr4); end
`ifdef CRITICAL_WORD_FIRST_EN
    n_chk++; if (cv1 !== 1'b0 || cw1 !== 32'd0) begin n_fail++; $display("FAIL reset_crit got %0h/%0h want 0/0", cv1, cw1); end
`endif
    rst = 1'b0;
    #1;
    n_chk++; if (rr1 !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready got %0h want 1", rr1); end
    n_chk++; if (rr4 !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready4 got %0h want 1", rr4); end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    a = 32'h0000_1234;
    @(negedge clk); rv1 = 1'b1; ra1 = a;
    n_chk++; if (rr1 !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %0h want 1", rr1); end
    @(negedge clk); rv1 = 1'b0;
    for (int m = 0; m < 22; m++) begin
      n_chk++; if (rd1 !== (m <= 15)) begin n_fail++; $display("FAIL basic_mem_rd m=%0d got %0h want %0h", m, rd1, (m <= 15)); end
      n_chk++; if (ma1 !== exp_addr(a, (m <= 15) ? m : 15)) begin n_fail++; $display("FAIL basic_mem_addr m=%0d got %0h want %0h", m, ma1, exp_addr(a, (m <= 15) ? m : 15)); end
      n_chk++; if (bv1 !== (m == 17)) begin n_fail++; $display("FAIL basic_blk_valid m=%0d got %0h want %0h", m, bv1, (m == 17)); end
      n_chk++; if (bs1 !== (m <= 17)) begin n_fail++; $display("FAIL basic_busy m=%0d got %0h want %0h", m, bs1, (m <= 17)); end
      n_chk++; if (rr1 !== (m >= 18)) begin n_fail++; $display("FAIL basic_req_ready m=%0d got %0h want %0h", m, rr1, (m >= 18)); end
`ifdef CRITICAL_WORD_FIRST_EN
      n_chk++; if (cv1 !== (m == 2)) begin n_fail++; $display("FAIL basic_crit_valid m=%0d got %0h want %0h", m, cv1, (m == 2)); end
      if (m >= 2) begin
        n_chk++; if (cw1 !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_crit_word m=%0d got %0h want 1234", m, cw1); end
      end
`endif
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bd1[32*i +: 32] !== 32'h1200 + 32'(4*i)) begin n_fail++; $display("FAIL basic_word%0d got %0h want %0h", i, bd1[32*i +: 32], 32'h1200 + 32'(4*i)); end
    end
  endtask

  task automatic test_latency4();
    logic [31:0] a;
    a = 32'h0000_0040;
    @(negedge clk); rv4 = 1'b1; ra4 = a;
    @(negedge clk); rv4 = 1'b0;
    for (int m = 0; m < 24; m++) begin
      n_chk++; if (rd4 !== (m <= 15)) begin n_fail++; $display("FAIL lat4_mem_rd m=%0d got %0h want %0h", m, rd4, (m <= 15)); end
      if (m <= 15) begin
        n_chk++; if (ma4 !== exp_addr(a, m)) begin n_fail++; $display("FAIL lat4_mem_addr m=%0d got %0h want %0h", m, ma4, exp_addr(a, m)); end
      end
      n_chk++; if (bv4 !== (m == 20)) begin n_fail++; $display("FAIL lat4_blk_valid m=%0d got %0h want %0h", m, bv4, (m == 20)); end
      n_chk++; if (bs4 !== (m <= 20)) begin n_fail++; $display("FAIL lat4_busy m=%0d got %0h want %0h", m, bs4, (m <= 20)); end
      n_chk++; if (bd4[31:0] !== ((m >= 5) ? 32'h40 : 32'h0)) begin n_fail++; $display("FAIL lat4_word0 m=%0d got %0h want %0h", m, bd4[31:0], (m >= 5) ? 32'h40 : 32'h0); end
      if (m == 5) begin
        n_chk++; if (bd4[63:32] !== 32'h0) begin n_fail++; $display("FAIL lat4_word1_early got %0h want 0", bd4[63:32]); end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bd4[32*i +: 32] !== 32'h40 + 32'(4*i)) begin n_fail++; $display("FAIL lat4_word%0d got %0h want %0h", i, bd4[32*i +: 32], 32'h40 + 32'(4*i)); end
    end
  endtask

  task automatic test_ignore_busy();
    @(negedge clk); rv1 = 1'b1; ra1 = 32'h0000_1000;
    @(negedge clk);
    for (int m = 0; m < 40; m++) begin
      n_chk++; if (rd1 !== ((m <= 15) || (m >= 19 && m <= 34))) begin n_fail++; $display("FAIL ign_mem_rd m=%0d got %0h", m, rd1); end
      if (m <= 15) begin
        n_chk++; if (ma1 !== exp_addr(32'h1000, m)) begin n_fail++; $display("FAIL ign_addr1 m=%0d got %0h want %0h", m, ma1, exp_addr(32'h1000, m)); end
      end
      if (m >= 19 && m <= 34) begin
        n_chk++; if (ma1 !== exp_addr(32'h2000, m - 19)) begin n_fail++; $display("FAIL ign_addr2 m=%0d got %0h want %0h", m, ma1, exp_addr(32'h2000, m - 19)); end
      end
      n_chk++; if (rr1 !== ((m == 18) || (m >= 37))) begin n_fail++; $display("FAIL ign_req_ready m=%0d got %0h", m, rr1); end
      n_chk++; if (bv1 !== ((m == 17) || (m == 36))) begin n_fail++; $display("FAIL ign_blk_valid m=%0d got %0h", m, bv1); end
      if (m == 17) begin
        n_chk++; if (bd1[31:0] !== 32'h1000 || bd1[511:480] !== 32'h103C) begin n_fail++; $display("FAIL ign_block1 got %0h..%0h want 1000..103c", bd1[31:0], bd1[511:480]); end
      end
      if (m == 5) ra1 = 32'h0000_2000;
      if (m == 19) rv1 = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bd1[32*i +: 32] !== 32'h2000 + 32'(4*i)) begin n_fail++; $display("FAIL ign_word%0d got %0h want %0h", i, bd1[32*i +: 32], 32'h2000 + 32'(4*i)); end
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2, np;
    p1 = -1; p2 = -1; np = 0;
    @(negedge clk); rv1 = 1'b1; ra1 = 32'h0000_0100;
    @(negedge clk); ra1 = 32'h0000_0200;
    for (int m = 0; m < 40; m++) begin
      if (bv1 === 1'b1) begin
        np++;
        if (p1 < 0) p1 = m;
        else        p2 = m;
      end
      if (m == 18) begin
        n_chk++; if (bd1[31:0] !== 32'h100 || bd1[511:480] !== 32'h13C) begin n_fail++; $display("FAIL b2b_block1 got %0h..%0h want 100..13c", bd1[31:0], bd1[511:480]); end
      end
      if (m == 19) rv1 = 1'b0;
      @(negedge clk);
    end
    n_chk++; if (np !== 2) begin n_fail++; $display("FAIL b2b_pulse_count got %0d want 2", np); end
    n_chk++; if (p1 !== 17) begin n_fail++; $display("FAIL b2b_first_pulse got %0d want 17", p1); end
    n_chk++; if (p2 - p1 !== 19) begin n_fail++; $display("FAIL b2b_separation got %0d want 19", p2 - p1); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bd1[32*i +: 32] !== 32'h200 + 32'(4*i)) begin n_fail++; $display("FAIL b2b_word%0d got %0h want %0h", i, bd1[32*i +: 32], 32'h200 + 32'(4*i)); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk); rv1 = 1'b1; ra1 = 32'h0000_3000;
    @(negedge clk); rv1 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (rr1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_ready got %0h want 0", rr1); end
    @(negedge clk);
    n_chk++; if (rd1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_rd got %0h want 0", rd1); end
    n_chk++; if (ma1 !== 32'd0) begin n_fail++; $display("FAIL rstmid_mem_addr got %0h want 0", ma1); end
    n_chk++; if (bd1 !== 512'd0) begin n_fail++; $display("FAIL rstmid_blk_data got nonzero want 0"); end
    n_chk++; if (bs1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0h want 0", bs1); end
    rst = 1'b0;
    for (int m = 0; m < 20; m++) begin
      n_chk++; if (bv1 !== 1'b0 || rd1 !== 1'b0 || bd1 !== 512'd0) begin n_fail++; $display("FAIL rstmid_quiet m=%0d valid=%0h rd=%0h", m, bv1, rd1); end
      @(negedge clk);
    end
    rv1 = 1'b1; ra1 = 32'h0000_4000;
    @(negedge clk); rv1 = 1'b0;
    for (int m = 0; m < 20; m++) begin
      n_chk++; if (bv1 !== (m == 17)) begin n_fail++; $display("FAIL rstmid_blk_valid m=%0d got %0h want %0h", m, bv1, (m == 17)); end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bd1[32*i +: 32] !== 32'h4000 + 32'(4*i)) begin n_fail++; $display("FAIL rstmid_word%0d got %0h want %0h", i, bd1[32*i +: 32], 32'h4000 + 32'(4*i)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency4();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_block_server.md
Name: rom_block_server

Overview:
Memory-side responder for cache line refills. It accepts a block request from the cache controller's refill path, reads a 512-bit block from a 32-bit-wide synchronous ROM as 16 consecutive word reads, assembles the block, and returns it with a one-cycle completion pulse. The cache controller uses that pulse as its "replaced" indication.

Parameters:
ADDR_W, 32, width of request and ROM byte addresses
WORD_W, 32, ROM data width; fixed at 32 (4-byte words)
BLOCK_WORDS, 16, words per block; block = 512 bits = 64 bytes
MEM_LATENCY, 1, cycles from mem_rd high to mem_data valid; legal range 1..4

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
req_valid  in  1  refill request present
req_addr  in  ADDR_W  byte address of the missing word
req_ready  out  1  server can accept; high only in IDLE and not in reset
mem_rd  out  1  ROM read strobe, one word per cycle
mem_addr  out  ADDR_W  ROM byte address, word aligned
mem_data  in  WORD_W  ROM read data, valid MEM_LATENCY cycles after mem_rd
blk_data  out  BLOCK_WORDS*WORD_W  assembled block
blk_valid  out  1  one-cycle pulse: blk_data complete
busy  out  1  high in FETCH and DONE

Behaviour:
- Reset (sys_rst high at edge): state IDLE; mem_rd=0, mem_addr=0, blk_data=0, blk_valid=0, busy=0; capture pipeline flushed. req_ready=0 while sys_rst is high.
- Handshake: request accepted on an edge where req_valid && req_ready. base = req_addr with bits [5:0] cleared. req_valid while busy is ignored and does not queue. Requester holds req_valid until accepted.
- FSM IDLE -> FETCH on accept. FETCH -> DONE the cycle after the 16th word is captured. DONE -> IDLE unconditionally after 1 cycle.
- FETCH issue: issue counter k=0..15. mem_rd=1 and mem_addr=base+4*k for 16 consecutive cycles starting the cycle after acceptance. mem_rd=0 afterwards. mem_addr holds its last value when mem_rd=0.
- Capture: a MEM_LATENCY-deep shift pipeline carries (valid, word index). On an edge where the delayed valid is high, mem_data is written into blk_data[32*i+31 : 32*i] for index i (word 0 in LSBs).
- Timing: acceptance at edge E. mem_rd is high in cycles E+1..E+16. blk_valid is high for exactly the one cycle E+17+MEM_LATENCY (DONE). req_ready returns high the following cycle.
- blk_data holds its value after DONE until the next accepted request overwrites it word by word. It is not cleared on accept.
- Index and address arithmetic is modulo 16 words within the block. mem_addr never leaves [base, base+0x3C]. An address carry into bit 6 is a bug.
- Reset mid-FETCH: immediate return to IDLE with reset values. In-flight ROM returns are discarded and do not write blk_data. No blk_valid pulse.
- req_valid in the same cycle as blk_valid: not accepted (req_ready=0 in DONE). Accepted on the next IDLE cycle.

Optional Feature:
Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - Issue order starts at word s=req_addr[5:2] and wraps modulo 16: s, s+1, ..., 15, 0, ..., s-1.
  - Words are still placed by absolute index.
  - Extra outputs: crit_valid (1 bit) pulses once when word s is captured (edge E+1+MEM_LATENCY). crit_word (WORD_W bits) holds that word until the next accept. Both reset to 0.
  - Total latency is unchanged.
- Undefined: issue always starts at word 0. The ports crit_valid and crit_word do not exist.

Test Plan:
- ROM model mem_data = mem_addr, MEM_LATENCY=1. Request 0x0000_1234 -> mem_addr 0x1200..0x123C over 16 cycles. blk_data[31:0]=0x1200, blk_data[511:480]=0x123C. blk_valid is a single pulse at E+18.
- req_valid held high through FETCH with addr 0x2000 changed mid-fetch -> ignored (req_ready=0). Next acceptance occurs only after DONE. Addresses for the first block are unchanged.
- MEM_LATENCY=4, request 0x0000_0040 -> blk_valid at E+21. blk_data words 0x40..0x7C in order. No capture before E+5.
- sys_rst pulsed for 1 cycle at E+8 of a fetch of 0x3000 -> all outputs 0, no blk_valid. The next request 0x4000 completes correctly with no 0x30xx words in blk_data.
- Back-to-back: request 0x100 then 0x200 presented continuously -> two blk_valid pulses separated by exactly 19 cycles (MEM_LATENCY=1). blk_data equals block 0x200 after the second pulse.
- CRITICAL_WORD_FIRST_EN, request 0x0000_1234 -> issue order 0x1234, 0x1238, 0x123C, 0x1200, ..., 0x1230. crit_valid at E+2 with crit_word=0x1234. Final blk_data is identical to scenario 1.
